// File: rtl/regfile_pkg.sv
// Shared register-file types and sizes, used by the register file, the write-back mux and the controller.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: capture on enable, hold otherwise.
// Optional write-first forwarding when REGFILE_BYPASS_EN is defined.
module regfile_read_port
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  reg_addr_t addr,
    input  data_t     rd_data,
    input  logic      rd_valid,
    input  logic      w_en,
    input  reg_addr_t w_addr,
    input  data_t     w_data,
    output data_t     data,
    output logic      valid
);

    data_t data_reg;
    data_t data_next;
    logic  valid_reg;
    logic  valid_next;

`ifdef REGFILE_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = w_en && (w_addr == addr);
`else
    // Write-port signals only matter for forwarding; keep them visibly consumed.
    logic unused_bypass_inputs;
    assign unused_bypass_inputs = ^{w_en, w_addr, w_data};
`endif

    always_comb begin
        data_next  = data_reg;
        valid_next = valid_reg;
        if (en) begin
`ifdef REGFILE_BYPASS_EN
            if (bypass_hit) begin
                data_next  = w_data;
                valid_next = 1'b1;
            end else begin
                data_next  = rd_data;
                valid_next = rd_valid;
            end
`else
            data_next  = rd_data;
            valid_next = rd_valid;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            data_reg  <= data_next;
            valid_reg <= valid_next;
        end
    end

    assign data  = data_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/register_file.sv
// 16x16 CPU register file with two registered read ports and per-register written flags.
// Define REGFILE_BYPASS_EN for write-first forwarding on the read ports.
module register_file
    import regfile_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset,
    input  data_t               W_data,
    input  reg_addr_t           W_addr,
    input  logic                W_en,
    input  reg_addr_t           Ra_addr,
    input  logic                Ra_en,
    input  reg_addr_t           Rb_addr,
    input  logic                Rb_en,
    output data_t               Ra_data,
    output data_t               Rb_data,
    output logic                Ra_valid,
    output logic                Rb_valid,
    output logic [NUM_REGS-1:0] Valid_vec
);

    data_t               mem_reg [NUM_REGS];
    logic [NUM_REGS-1:0] valid_reg;
    logic [NUM_REGS-1:0] wr_sel;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
            assign wr_sel[gi] = W_en && (W_addr == ADDR_W'(gi));
        end
    endgenerate

    // Async clear of the whole array means this maps to flops, not block RAM.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_reg[i] <= '0;
            end
            valid_reg <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    mem_reg[i]   <= W_data;
                    valid_reg[i] <= 1'b1;
                end
            end
        end
    end

    assign Valid_vec = valid_reg;

    data_t ra_mem_data;
    data_t rb_mem_data;
    logic  ra_mem_valid;
    logic  rb_mem_valid;

    assign ra_mem_data  = mem_reg[Ra_addr];
    assign rb_mem_data  = mem_reg[Rb_addr];
    assign ra_mem_valid = valid_reg[Ra_addr];
    assign rb_mem_valid = valid_reg[Rb_addr];

    regfile_read_port u_port_a (
        .clk      (Clk),
        .rst      (Reset),
        .en       (Ra_en),
        .addr     (Ra_addr),
        .rd_data  (ra_mem_data),
        .rd_valid (ra_mem_valid),
        .w_en     (W_en),
        .w_addr   (W_addr),
        .w_data   (W_data),
        .data     (Ra_data),
        .valid    (Ra_valid)
    );

    regfile_read_port u_port_b (
        .clk      (Clk),
        .rst      (Reset),
        .en       (Rb_en),
        .addr     (Rb_addr),
        .rd_data  (rb_mem_data),
        .rd_valid (rb_mem_valid),
        .w_en     (W_en),
        .w_addr   (W_addr),
        .w_data   (W_data),
        .data     (Rb_data),
        .valid    (Rb_valid)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file; expectations follow REGFILE_BYPASS_EN when defined.
module tb_register_file;
    import regfile_pkg::*;

    logic                Clk = 1'b0;
    logic                Reset;
    data_t               W_data;
    reg_addr_t           W_addr;
    logic                W_en;
    reg_addr_t           Ra_addr;
    logic                Ra_en;
    reg_addr_t           Rb_addr;
    logic                Rb_en;
    data_t               Ra_data;
    data_t               Rb_data;
    logic                Ra_valid;
    logic                Rb_valid;
    logic [NUM_REGS-1:0] Valid_vec;

    int checks = 0;
    int errors = 0;

    register_file dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .W_data    (W_data),
        .W_addr    (W_addr),
        .W_en      (W_en),
        .Ra_addr   (Ra_addr),
        .Ra_en     (Ra_en),
        .Rb_addr   (Rb_addr),
        .Rb_en     (Rb_en),
        .Ra_data   (Ra_data),
        .Rb_data   (Rb_data),
        .Ra_valid  (Ra_valid),
        .Rb_valid  (Rb_valid),
        .Valid_vec (Valid_vec)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance one edge; inputs are changed and outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        W_en  = 1'b0;
        Ra_en = 1'b0;
        Rb_en = 1'b0;
    endtask

    task automatic write_reg(input reg_addr_t a, input data_t d);
        idle();
        W_en   = 1'b1;
        W_addr = a;
        W_data = d;
        tick();
        W_en = 1'b0;
    endtask

    task automatic read_a(input reg_addr_t a);
        idle();
        Ra_en   = 1'b1;
        Ra_addr = a;
        tick();
        Ra_en = 1'b0;
    endtask

    task automatic read_b(input reg_addr_t a);
        idle();
        Rb_en   = 1'b1;
        Rb_addr = a;
        tick();
        Rb_en = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        W_data = '0; W_addr = '0; Ra_addr = '0; Rb_addr = '0;
        idle();
        #2;
        check("reset_ra_data", 32'(Ra_data), 32'h0000);
        check("reset_rb_data", 32'(Rb_data), 32'h0000);
        check("reset_valid_vec", 32'(Valid_vec), 32'h0000);
        check("reset_ra_valid", 32'(Ra_valid), 32'h0);
        tick();
        tick();
        Reset = 1'b0;

        // Reset mid-operation
        write_reg(4'd3, 16'hBEEF);
        idle();
        Ra_en = 1'b1; Ra_addr = 4'd3;
        Rb_en = 1'b1; Rb_addr = 4'd3;
        tick();
        idle();
        check("pre_reset_ra", 32'(Ra_data), 32'hBEEF);
        check("pre_reset_vv", 32'(Valid_vec), 32'h0008);
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst_ra", 32'(Ra_data), 32'h0000);
        check("async_rst_rb", 32'(Rb_data), 32'h0000);
        check("async_rst_vv", 32'(Valid_vec), 32'h0000);
        check("async_rst_rav", 32'(Ra_valid), 32'h0);
        W_en = 1'b1; W_addr = 4'd3; W_data = 16'h1234;
        Ra_en = 1'b1; Ra_addr = 4'd3;
        tick();
        check("rst_dominates_vv", 32'(Valid_vec), 32'h0000);
        check("rst_dominates_ra", 32'(Ra_data), 32'h0000);
        idle();
        Reset = 1'b0;
        read_a(4'd3);
        check("post_rst_r3", 32'(Ra_data), 32'h0000);
        check("post_rst_r3_v", 32'(Ra_valid), 32'h0);

        // Basic write/read
        write_reg(4'd5, 16'h1234);
        read_a(4'd5);
        check("basic_r5", 32'(Ra_data), 32'h1234);
        check("basic_r5_v", 32'(Ra_valid), 32'h1);
        check("basic_vv", 32'(Valid_vec), 32'h0020);

        // Dual port, same address; R0 writable
        write_reg(4'd7, 16'hA5A5);
        idle();
        Ra_en = 1'b1; Ra_addr = 4'd7;
        Rb_en = 1'b1; Rb_addr = 4'd7;
        tick();
        idle();
        check("dual_a", 32'(Ra_data), 32'hA5A5);
        check("dual_b", 32'(Rb_data), 32'hA5A5);
        check("dual_av", 32'(Ra_valid), 32'h1);
        check("dual_bv", 32'(Rb_valid), 32'h1);
        write_reg(4'd0, 16'h00FF);
        read_b(4'd0);
        check("r0_b", 32'(Rb_data), 32'h00FF);
        check("r0_bv", 32'(Rb_valid), 32'h1);
        check("r0_a_untouched", 32'(Ra_data), 32'hA5A5);

        // Read-during-write: port A on a written reg, port B on a never-written one
        write_reg(4'd2, 16'h1111);
        idle();
        W_en = 1'b1; W_addr = 4'd2; W_data = 16'h2222;
        Ra_en = 1'b1; Ra_addr = 4'd2;
        tick();
        idle();
`ifdef REGFILE_BYPASS_EN
        check("rdw_a", 32'(Ra_data), 32'h2222);
`else
        check("rdw_a", 32'(Ra_data), 32'h1111);
`endif
        check("rdw_a_v", 32'(Ra_valid), 32'h1);
        W_en = 1'b1; W_addr = 4'd6; W_data = 16'h6666;
        Rb_en = 1'b1; Rb_addr = 4'd6;
        tick();
        idle();
`ifdef REGFILE_BYPASS_EN
        check("rdw_b", 32'(Rb_data), 32'h6666);
        check("rdw_b_v", 32'(Rb_valid), 32'h1);
`else
        check("rdw_b", 32'(Rb_data), 32'h0000);
        check("rdw_b_v", 32'(Rb_valid), 32'h0);
`endif
        read_a(4'd2);
        check("rdw_next_a", 32'(Ra_data), 32'h2222);
        read_b(4'd6);
        check("rdw_next_b", 32'(Rb_data), 32'h6666);
        check("rdw_next_bv", 32'(Rb_valid), 32'h1);

        // Hold and isolation
        write_reg(4'd4, 16'h0F0F);
        read_a(4'd4);
        check("hold_cap", 32'(Ra_data), 32'h0F0F);
        Ra_addr = 4'd4;
        write_reg(4'd4, 16'hFFFF);
        check("hold_1", 32'(Ra_data), 32'h0F0F);
        tick();
        check("hold_2", 32'(Ra_data), 32'h0F0F);
        read_a(4'd4);
        check("hold_reen", 32'(Ra_data), 32'hFFFF);
        write_reg(4'd8, 16'h8888);
        check("isolate_a", 32'(Ra_data), 32'hFFFF);
        read_a(4'd9);
        check("r9_data", 32'(Ra_data), 32'h0000);
        check("r9_valid", 32'(Ra_valid), 32'h0);

        // Full sweep
        for (int i = 0; i < NUM_REGS; i++) begin
            write_reg(ADDR_W'(i), 16'h1000 + 16'(i));
        end
        check("sweep_vv", 32'(Valid_vec), 32'hFFFF);
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i % 2 == 0) begin
                read_a(ADDR_W'(i));
                check($sformatf("sweep_a%0d", i), 32'(Ra_data), 32'h1000 + 32'(i));
                check($sformatf("sweep_a%0d_v", i), 32'(Ra_valid), 32'h1);
            end else begin
                read_b(ADDR_W'(i));
                check($sformatf("sweep_b%0d", i), 32'(Rb_data), 32'h1000 + 32'(i));
                check($sformatf("sweep_b%0d_v", i), 32'(Rb_valid), 32'h1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
